// File: rtl/tri_src_drv.sv
// tri_src_drv: FIFO-backed triangle transmitter with valid/halt handshake,
// per-triangle sequence IDs and optional idle gaps between transfers.
module tri_src_drv #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4,
  parameter int GAP    = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] wr_tri_S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          wr_color_U,
  input  logic                                         wr_valid_H,
  output logic                                         wr_ready_H,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U,
  output logic                                         validTri_R10H,
  output logic        [15:0]                           tri_id_R10U,
  input  logic                                         halt_RnnnnL,
  output logic        [31:0]                           count_sent_U,
  output logic        [$clog2(DEPTH):0]                fifo_level_U,
  output logic                                         idle_H
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RADIX >= SIGFIG) begin : g_bad_cfg
    $error("tri_src_drv: DEPTH must be a power of two >= 2 and RADIX < SIGFIG");
  end
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_mem [DEPTH];
  logic        [COLORS-1:0][SIGFIG-1:0]          col_mem [DEPTH];
  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic [AW:0]   wptr_q, rptr_q;
  logic [15:0]   id_q, id_next_q;
  logic [31:0]   count_q;
  logic [GW-1:0] gap_q;
  logic          valid_q, push, xfer, empty, load;
  state_e        state_q;
  assign fifo_level_U  = wptr_q - rptr_q;
  assign empty         = wptr_q == rptr_q;
  // level never exceeds DEPTH, so the top bit alone means full
  assign wr_ready_H    = !fifo_level_U[AW];
  assign push          = wr_valid_H && wr_ready_H;
  assign xfer          = valid_q && halt_RnnnnL;
  // a transfer only chains straight into the next load when no gap is configured
  assign load          = !empty && gap_q == '0 && (!valid_q || (xfer && GAP == 0));
  assign idle_H        = empty && !valid_q;
  assign tri_R10S      = tri_q;
  assign color_R10U    = color_q;
  assign validTri_R10H = valid_q;
  assign tri_id_R10U   = id_q;
  assign count_sent_U  = count_q;
  always_ff @(posedge clk) begin
    if (push) begin
      tri_mem[wptr_q[AW-1:0]] <= wr_tri_S;
      col_mem[wptr_q[AW-1:0]] <= wr_color_U;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      tri_q     <= '0;
      color_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      id_next_q <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      state_q   <= S_IDLE;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (xfer) count_q <= count_q + 32'd1;
      if (load) begin
        rptr_q    <= rptr_q + 1'b1;
        tri_q     <= tri_mem[rptr_q[AW-1:0]];
        color_q   <= col_mem[rptr_q[AW-1:0]];
        valid_q   <= 1'b1;
        id_q      <= id_next_q;
        id_next_q <= id_next_q + 16'd1;
        state_q   <= S_SEND;
      end else if (xfer) begin
        valid_q <= 1'b0;
        state_q <= GAP > 0 ? S_GAP : S_IDLE;
        // loaded with GAP-1 so the reload edge itself is the last idle cycle
        gap_q   <= GW'(GAP > 0 ? GAP - 1 : 0);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end else if (state_q == S_GAP) begin
        state_q <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_tri_src_drv.sv
// tb_tri_src_drv: table-driven and model-checked bench for tri_src_drv.
module tb_tri_src_drv;
  localparam int SF = 24, V = 3, A = 3, C = 3, D = 4;
  typedef logic signed [V-1:0][A-1:0][SF-1:0] tri_t;
  typedef logic [C-1:0][SF-1:0] col_t;
  typedef struct { tri_t t; col_t c; } ent_t;
  typedef struct {
    logic rn, wv, h, ev;
    int   eid, ec, el;
    logic er, ei;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, wv, halt, rdy, vld, idle;
  tri_t wt, ot;
  col_t wc, oc;
  logic [15:0] oid;
  logic [31:0] cnt;
  logic [2:0]  lvl;
  logic g_rst, g_wv, g_halt, g_rdy, g_vld, g_idle;
  tri_t g_t, g_ot;
  col_t g_c, g_oc;
  logic [15:0] g_oid;
  logic [31:0] g_cnt;
  logic [2:0]  g_lvl;
  tri_src_drv #(.DEPTH(D)) u0 (
    .clk(clk), .rst(rst_n), .wr_tri_S(wt), .wr_color_U(wc), .wr_valid_H(wv),
    .wr_ready_H(rdy), .tri_R10S(ot), .color_R10U(oc), .validTri_R10H(vld),
    .tri_id_R10U(oid), .halt_RnnnnL(halt), .count_sent_U(cnt),
    .fifo_level_U(lvl), .idle_H(idle)
  );
  tri_src_drv #(.DEPTH(D), .GAP(2)) u2 (
    .clk(clk), .rst(g_rst), .wr_tri_S(g_t), .wr_color_U(g_c), .wr_valid_H(g_wv),
    .wr_ready_H(g_rdy), .tri_R10S(g_ot), .color_R10U(g_oc), .validTri_R10H(g_vld),
    .tri_id_R10U(g_oid), .halt_RnnnnL(g_halt), .count_sent_U(g_cnt),
    .fifo_level_U(g_lvl), .idle_H(g_idle)
  );
  int vectors = 0, miss = 0;
  vec_t tbl[$];
  ent_t mq[$];
  ent_t m_bus;
  logic m_v;
  logic [15:0] m_id, m_next;
  logic [31:0] m_cnt;
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic tri_t mk_tri(input int n);
    tri_t t;
    for (int v = 0; v < V; v++)
      for (int a = 0; a < A; a++) t[v][a] = SF'(32'h80_0000 ^ (n * 16 + v * 4 + a));
    return t;
  endfunction
  function automatic col_t mk_col(input int n);
    col_t c;
    for (int k = 0; k < C; k++) c[k] = SF'(32'hC0_0000 | (n * 8 + k));
    return c;
  endfunction
  function automatic tri_t rtri();
    tri_t t;
    for (int v = 0; v < V; v++)
      for (int a = 0; a < A; a++) t[v][a] = SF'($urandom);
    return t;
  endfunction
  function automatic col_t rcol();
    col_t c;
    for (int k = 0; k < C; k++) c[k] = SF'($urandom);
    return c;
  endfunction
  task automatic add(input logic rn, wv_, h, ev, input int eid, ec, el, input logic er, ei);
    vec_t r;
    r = '{rn, wv_, h, ev, eid, ec, el, er, ei};
    tbl.push_back(r);
  endtask
  task automatic mreset();
    mq.delete();
    m_v = 1'b0; m_bus.t = '0; m_bus.c = '0;
    m_id = '0; m_next = '0; m_cnt = '0;
  endtask
  task automatic check_all();
    chk("valid", 256'(vld), 256'(m_v));
    chk("count", 256'(cnt), 256'(m_cnt));
    chk("level", 256'(lvl), 256'(mq.size()));
    chk("ready", 256'(rdy), 256'(mq.size() < D));
    chk("idle", 256'(idle), 256'(mq.size() == 0 && !m_v));
    if (m_v) begin
      chk("id", 256'(oid), 256'(m_id));
      chk("tri", 256'(ot), 256'(m_bus.t));
      chk("color", 256'(oc), 256'(m_bus.c));
    end
  endtask
  // The model treats the block as a queue of accepted triangles plus one bus slot.
  task automatic step(input logic v, input tri_t t, input col_t c, input logic h, input bit ck);
    logic x, p, l;
    wv = v; wt = t; wc = c; halt = h;
    x = m_v && h;
    p = v && mq.size() < D;
    l = mq.size() > 0 && (!m_v || x);
    if (x) m_cnt++;
    if (l) begin
      m_bus = mq.pop_front();
      m_id = m_next;
      m_next++;
      m_v = 1'b1;
    end else if (x) m_v = 1'b0;
    if (p) mq.push_back('{t, c});
    @(negedge clk);
    if (ck) check_all();
  endtask
  task automatic reset0();
    rst_n = 1'b0; wv = 1'b0; halt = 1'b1;
    mreset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    int wcnt;
    bit acc;
    tri_t t;
    col_t c;
    logic [6:0] pat;
    rst_n = 1'b0; wv = 1'b0; halt = 1'b1; wt = '0; wc = '0;
    g_rst = 1'b0; g_wv = 1'b0; g_halt = 1'b1; g_t = '0; g_c = '0;
    add(0,0,1, 0,0,0,0, 1,1);
    add(1,1,1, 0,0,0,1, 1,0);
    add(1,0,1, 1,0,0,0, 1,0);
    add(1,0,1, 0,0,1,0, 1,1);
    add(0,0,1, 0,0,0,0, 1,1);
    add(1,1,0, 0,0,0,1, 1,0);
    add(1,1,0, 1,0,0,1, 1,0);
    add(1,1,0, 1,0,0,2, 1,0);
    add(1,1,0, 1,0,0,3, 1,0);
    add(1,1,0, 1,0,0,4, 0,0);
    add(1,1,0, 1,0,0,4, 0,0);
    add(1,1,0, 1,0,0,4, 0,0);
    add(1,1,0, 1,0,0,4, 0,0);
    add(1,1,1, 1,1,1,3, 1,0);
    add(1,1,1, 1,2,2,3, 1,0);
    add(1,0,1, 1,3,3,2, 1,0);
    add(1,0,1, 1,4,4,1, 1,0);
    add(1,0,1, 1,5,5,0, 1,0);
    add(1,0,1, 0,0,6,0, 1,1);
    wcnt = 0;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rn;
      if (!tbl[i].rn) wcnt = 0;
      wv = tbl[i].wv; halt = tbl[i].h; wt = mk_tri(wcnt); wc = mk_col(wcnt);
      #1;
      acc = wv && rdy && rst_n;
      @(negedge clk);
      if (acc) wcnt++;
      chk($sformatf("t%0d_valid", i), 256'(vld), 256'(tbl[i].ev));
      chk($sformatf("t%0d_count", i), 256'(cnt), 256'(tbl[i].ec));
      chk($sformatf("t%0d_level", i), 256'(lvl), 256'(tbl[i].el));
      chk($sformatf("t%0d_ready", i), 256'(rdy), 256'(tbl[i].er));
      chk($sformatf("t%0d_idle", i), 256'(idle), 256'(tbl[i].ei));
      if (tbl[i].ev) begin
        chk($sformatf("t%0d_id", i), 256'(oid), 256'(tbl[i].eid));
        chk($sformatf("t%0d_tri", i), 256'(ot), 256'(mk_tri(tbl[i].eid)));
        chk($sformatf("t%0d_color", i), 256'(oc), 256'(mk_col(tbl[i].eid)));
      end
    end
    reset0();
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) reset0();
      else step($urandom_range(0, 9) < 6, rtri(), rcol(), $urandom_range(0, 9) < 7, 1'b1);
    end
    reset0();
    t = rtri(); c = rcol();
    step(1'b1, t, c, 1'b1, 1'b1);
    step(1'b1, t, c, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, t, c, 1'b1, 1'b1);
    chk("dup_count", 256'(cnt), 256'(2));
    reset0();
    for (int k = 0; k < 65545; k++) begin
      step(1'b1, mk_tri(k), mk_col(k), 1'b1, k >= 65530);
      if (k == 65536) chk("wrap_ffff", 256'(oid), 256'(16'hFFFF));
      if (k == 65537) chk("wrap_0000", 256'(oid), 256'(0));
    end
    step(1'b1, rtri(), rcol(), 1'b0, 1'b1);
    step(1'b1, rtri(), rcol(), 1'b0, 1'b1);
    chk("stall_level", 256'(lvl), 256'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(vld), 256'(0));
    chk("arst_tri", 256'(ot), 256'(0));
    chk("arst_color", 256'(oc), 256'(0));
    chk("arst_id", 256'(oid), 256'(0));
    chk("arst_count", 256'(cnt), 256'(0));
    chk("arst_level", 256'(lvl), 256'(0));
    chk("arst_idle", 256'(idle), 256'(1));
    chk("arst_ready", 256'(rdy), 256'(1));
    mreset();
    wv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, rtri(), rcol(), 1'b1, 1'b1);
    step(1'b0, rtri(), rcol(), 1'b1, 1'b1);
    chk("post_rst_id", 256'(oid), 256'(0));
    g_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      g_wv = 1'b1; g_t = mk_tri(i); g_c = mk_col(i); g_halt = 1'b0;
      @(negedge clk);
    end
    g_wv = 1'b0; g_halt = 1'b1;
    pat = 7'b1001001;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("gap_valid%0d", i), 256'(g_vld), 256'(pat[6-i]));
      if (pat[6-i]) begin
        chk($sformatf("gap_id%0d", i), 256'(g_oid), 256'(i / 3));
        chk($sformatf("gap_tri%0d", i), 256'(g_ot), 256'(mk_tri(i / 3)));
      end
      @(negedge clk);
    end
    chk("gap_count", 256'(g_cnt), 256'(3));
    chk("gap_idle", 256'(g_idle), 256'(1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
